// File: rtl/row_access_sequencer.sv
// Row access sequencer: round-robin arbitration of two requesters, then PRECHARGE/ACTIVE/RECOVER
// phasing for the row decoder. Define REFRESH_EN to add periodic refresh accesses with priority.
module row_access_sequencer #(
    parameter int ADDR_W     = 4,
    parameter int PRE_CYC    = 2,
    parameter int ACT_CYC    = 3,
    parameter int REF_PERIOD = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic              req_b,
    input  logic [ADDR_W-1:0] addr_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic [ADDR_W-1:0] row_addr,
    output logic              precharge,
    output logic              wl_en,
    output logic              busy,
    output logic              done
`ifdef REFRESH_EN
    ,
    output logic              ref_busy
`endif
);

    localparam int MAX_CYC = (PRE_CYC > ACT_CYC) ? PRE_CYC : ACT_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    typedef enum logic [1:0] {
        IDLE,
        PRECHARGE,
        ACTIVE,
        RECOVER
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              last_b, last_b_nxt;
    logic [ADDR_W-1:0] row_addr_nxt;
    logic              gnt_a_nxt, gnt_b_nxt, precharge_nxt, wl_en_nxt, busy_nxt, done_nxt;
    logic              ref_start;

`ifdef REFRESH_EN
    localparam int REF_W = $clog2(REF_PERIOD);
    logic [REF_W-1:0]  ref_cnt;
    logic              ref_pending;
    logic [ADDR_W-1:0] ref_row;
    logic              ref_busy_nxt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            last_b    <= 1'b1;
            row_addr  <= '0;
            gnt_a     <= 1'b0;
            gnt_b     <= 1'b0;
            precharge <= 1'b0;
            wl_en     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            last_b    <= last_b_nxt;
            row_addr  <= row_addr_nxt;
            gnt_a     <= gnt_a_nxt;
            gnt_b     <= gnt_b_nxt;
            precharge <= precharge_nxt;
            wl_en     <= wl_en_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        last_b_nxt    = last_b;
        row_addr_nxt  = row_addr;
        gnt_a_nxt     = 1'b0;
        gnt_b_nxt     = 1'b0;
        precharge_nxt = precharge;
        wl_en_nxt     = wl_en;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        ref_start     = 1'b0;
`ifdef REFRESH_EN
        ref_busy_nxt  = ref_busy;
`endif
        case (state)
            IDLE: begin
                // A pending refresh outranks both requesters and leaves last_b alone.
`ifdef REFRESH_EN
                if (ref_pending) begin
                    ref_start    = 1'b1;
                    ref_busy_nxt = 1'b1;
                    row_addr_nxt = ref_row;
                end else
`endif
                if (req_a && (!req_b || last_b)) begin
                    gnt_a_nxt    = 1'b1;
                    last_b_nxt   = 1'b0;
                    row_addr_nxt = addr_a;
                end else if (req_b) begin
                    gnt_b_nxt    = 1'b1;
                    last_b_nxt   = 1'b1;
                    row_addr_nxt = addr_b;
                end
                if (ref_start || gnt_a_nxt || gnt_b_nxt) begin
                    state_nxt     = PRECHARGE;
                    cnt_nxt       = CNT_W'(PRE_CYC - 1);
                    busy_nxt      = 1'b1;
                    precharge_nxt = 1'b1;
                end
            end
            PRECHARGE: begin
                if (cnt == '0) begin
                    state_nxt     = ACTIVE;
                    cnt_nxt       = CNT_W'(ACT_CYC - 1);
                    precharge_nxt = 1'b0;
                    wl_en_nxt     = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ACTIVE: begin
                if (cnt == '0) begin
                    state_nxt     = RECOVER;
                    wl_en_nxt     = 1'b0;
                    precharge_nxt = 1'b1;
                    done_nxt      = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            RECOVER: begin
                state_nxt     = IDLE;
                precharge_nxt = 1'b0;
                busy_nxt      = 1'b0;
`ifdef REFRESH_EN
                ref_busy_nxt  = 1'b0;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef REFRESH_EN
    // Expiry while a refresh is already pending is simply absorbed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt     <= REF_W'(REF_PERIOD - 1);
            ref_pending <= 1'b0;
            ref_row     <= '0;
            ref_busy    <= 1'b0;
        end else begin
            ref_busy <= ref_busy_nxt;
            if (ref_cnt == '0) begin
                ref_cnt <= REF_W'(REF_PERIOD - 1);
            end else begin
                ref_cnt <= ref_cnt - REF_W'(1);
            end
            if (ref_start) begin
                ref_pending <= 1'b0;
                ref_row     <= ref_row + ADDR_W'(1);
            end else if (ref_cnt == '0) begin
                ref_pending <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_row_access_sequencer.sv
// Bench for row_access_sequencer: access-age reference model checked every cycle, plus directed
// scenarios and a randomized phase. Refresh scenario is built when REFRESH_EN is defined.
module tb_row_access_sequencer;

    localparam int ADDR_W     = 4;
    localparam int PRE_CYC    = 2;
    localparam int ACT_CYC    = 3;
    localparam int REF_PERIOD = 64;
    localparam int ACC_LEN    = PRE_CYC + ACT_CYC + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_a = 1'b0, req_b = 1'b0;
    logic [ADDR_W-1:0] addr_a = '0, addr_b = '0;
    logic              gnt_a, gnt_b, precharge, wl_en, busy, done;
    logic [ADDR_W-1:0] row_addr;
`ifdef REFRESH_EN
    logic              ref_busy;
`endif

    int errors = 0;
    int checks = 0;

    row_access_sequencer #(
        .ADDR_W(ADDR_W), .PRE_CYC(PRE_CYC), .ACT_CYC(ACT_CYC), .REF_PERIOD(REF_PERIOD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .addr_a(addr_a), .req_b(req_b), .addr_b(addr_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .row_addr(row_addr),
        .precharge(precharge), .wl_en(wl_en), .busy(busy), .done(done)
`ifdef REFRESH_EN
        , .ref_busy(ref_busy)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: an access is described only by its age (cycles since it was accepted).
    bit              m_act, m_last_b, m_ga, m_gb, m_ref, m_pend;
    int              m_age, m_edges, m_ref_row;
    logic [ADDR_W-1:0] m_row;

    task automatic model_reset();
        m_act = 0; m_age = 0; m_last_b = 1; m_ga = 0; m_gb = 0; m_row = '0;
        m_ref = 0; m_pend = 0; m_edges = 0; m_ref_row = 0;
    endtask

    task automatic model_edge();
        bit tick, start_ref;
        tick = 0;
        start_ref = 0;
        m_ga = 0;
        m_gb = 0;
`ifdef REFRESH_EN
        m_edges++;
        tick = (m_edges % REF_PERIOD) == 0;
`endif
        if (!m_act) begin
            if (m_pend) begin
                start_ref = 1;
                m_act = 1; m_age = 1; m_ref = 1;
                m_row = ADDR_W'(m_ref_row);
                m_ref_row = (m_ref_row + 1) % (1 << ADDR_W);
            end else if (req_a || req_b) begin
                if (req_a && (!req_b || m_last_b)) begin
                    m_ga = 1; m_last_b = 0; m_row = addr_a;
                end else begin
                    m_gb = 1; m_last_b = 1; m_row = addr_b;
                end
                m_act = 1; m_age = 1; m_ref = 0;
            end
        end else if (m_age == ACC_LEN) begin
            m_act = 0; m_age = 0; m_ref = 0;
        end else begin
            m_age++;
        end
        if (start_ref) m_pend = 0;
        else if (tick) m_pend = 1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit e_pre, e_wl, e_done;
        e_pre  = m_act && (m_age <= PRE_CYC || m_age == ACC_LEN);
        e_wl   = m_act && (m_age > PRE_CYC) && (m_age <= PRE_CYC + ACT_CYC);
        e_done = m_act && (m_age == ACC_LEN);
        check("gnt_a", gnt_a, m_ga);
        check("gnt_b", gnt_b, m_gb);
        check("row_addr", row_addr, m_row);
        check("precharge", precharge, e_pre);
        check("wl_en", wl_en, e_wl);
        check("busy", busy, m_act);
        check("done", done, e_done);
        check("no_overlap", wl_en & precharge, 1'b0);
`ifdef REFRESH_EN
        check("ref_busy", ref_busy, m_act && m_ref);
`endif
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    // Asserts reset away from any clock edge, checks the immediate effect, releases on a negedge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        logic [ADDR_W-1:0] rows[$];
        int exp_rows[4];

        // Reset values
        do_reset();

        // Single A access, addr 9, with addr_a toggling after the grant
        req_a = 1'b1; addr_a = 4'd9;
        cycle();
        check("lat_gnt_a", gnt_a, 1'b1);
        check("lat_row9", row_addr, 4'd9);
        req_a = 1'b0;
        n = 1;
        while (!done && n < 20) begin
            addr_a = ~addr_a;
            cycle();
            n++;
            check("hold_row9", row_addr, 4'd9);
        end
        check("lat_done", n, ACC_LEN);
        cycle();

        // Reset in the middle of an ACTIVE phase on row 5
        req_a = 1'b1; addr_a = 4'd5;
        cycle();
        req_a = 1'b0;
        n = 0;
        while (!wl_en && n < 10) begin
            cycle();
            n++;
        end
        check("reach_active", wl_en, 1'b1);
        do_reset();
        check("rst_wl_en", wl_en, 1'b0);
        check("rst_row", row_addr, 4'd0);
        for (int i = 0; i < 8; i++) cycle();

        // Tie held on both requesters: alternate A,B,A,B
        exp_rows[0] = 3; exp_rows[1] = 12; exp_rows[2] = 3; exp_rows[3] = 12;
        req_a = 1'b1; addr_a = 4'd3; req_b = 1'b1; addr_b = 4'd12;
        n = 0;
        while (rows.size() < 4 && n < 60) begin
            cycle();
            n++;
            if (gnt_a || gnt_b) rows.push_back(row_addr);
        end
        check("tie_grants", rows.size(), 4);
        for (int i = 0; i < 4 && i < rows.size(); i++) check("tie_row", rows[i], exp_rows[i]);
        req_a = 1'b0; req_b = 1'b0;
        for (int i = 0; i < 8; i++) cycle();

        // Every row in order through B
        for (int r = 0; r < (1 << ADDR_W); r++) begin
            req_b = 1'b1; addr_b = ADDR_W'(r);
            n = 0;
            do begin
                cycle();
                n++;
            end while (!gnt_b && n < 12);
            check("sweep_gnt_b", gnt_b, 1'b1);
            check("sweep_row", row_addr, r);
            req_b = 1'b0;
        end
        for (int i = 0; i < 8; i++) cycle();

        // Randomized requesters obeying the hold-until-grant handshake
        for (int i = 0; i < 400; i++) begin
            if (!req_a) begin
                addr_a = ADDR_W'($urandom);
                if ($urandom_range(2) == 0) req_a = 1'b1;
            end else if (gnt_a) begin
                addr_a = ADDR_W'($urandom);
                req_a  = $urandom_range(1) == 0;
            end
            if (!req_b) begin
                addr_b = ADDR_W'($urandom);
                if ($urandom_range(2) == 0) req_b = 1'b1;
            end else if (gnt_b) begin
                addr_b = ADDR_W'($urandom);
                req_b  = $urandom_range(1) == 0;
            end
            cycle();
        end
        req_a = 1'b0; req_b = 1'b0;
        for (int i = 0; i < 8; i++) cycle();

`ifdef REFRESH_EN
        // Refresh preempts a continuously requesting A; rows walk 0,1,2,... and wrap
        begin
            bit prev_rb;
            int nref;
            do_reset();
            req_a = 1'b1; addr_a = ADDR_W'($urandom);
            prev_rb = 1'b0;
            nref = 0;
            n = 0;
            while (nref < 17 && n < 3000) begin
                cycle();
                n++;
                if (gnt_a) addr_a = ADDR_W'($urandom);
                if (ref_busy && !prev_rb) begin
                    check("ref_row", row_addr, nref % (1 << ADDR_W));
                    check("ref_no_gnt", gnt_a | gnt_b, 1'b0);
                    nref++;
                end
                prev_rb = ref_busy;
            end
            check("ref_count", nref, 17);
            req_a = 1'b0;
            for (int i = 0; i < 8; i++) cycle();
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
